i2c_master_arbiter: RTL and testbench

I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

---
 rtl/i2c_master_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin arbiter for two requesters in front of a
// single-byte I2C write master. SCL and SDA are open-drain: 0 or z only.
// Optional feature: define I2C_RETRY_ON_NACK_EN to retry a transfer once
// (STOP, repeated START, same owner) when the address byte is not ACKed.
module i2c_master_arbiter #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] grant,
  output logic       done,
  output logic       nack,
  output logic       busy,
  inout  wire        i2c_scl,
  inout  wire        i2c_sda,
  output logic [3:0] state_out
);

`ifdef I2C_RETRY_ON_NACK_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ARB   = 4'd1,
    START = 4'd2,
    ADDR  = 4'd3,
    ACK1  = 4'd4,
    DATA  = 4'd5,
    ACK2  = 4'd6,
    STOP  = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t     state;
  logic [9:0] cnt;
  logic       tick;
  logic       run;
  logic [1:0] q;          // quarter of the current bit / condition
  logic [2:0] bit_cnt;
  logic [7:0] shreg;      // shreg[7] is the bit currently on SDA
  logic [6:0] addr_lat;
  logic [7:0] data_lat;
  logic       scl_low;
  logic       sda_low;
  logic       sda_smp;
  logic       nack_flag;
  logic       last;       // index of the requester granted last
  logic       win;
  logic       retried;
  logic       retry_pend;

  assign i2c_scl   = scl_low ? 1'b0 : 1'bz;
  assign i2c_sda   = sda_low ? 1'b0 : 1'bz;
  assign state_out = state;

  assign run  = state inside {START, ADDR, ACK1, DATA, ACK2, STOP};
  assign tick = (cnt == 10'(CLK_DIV - 1));
  // a lone request wins; on a tie the requester not served last wins
  assign win  = (req == 2'b11) ? ~last : req[1];

  // quarter-period timebase; idle states hold it at zero so START begins fresh
  always_ff @(posedge clk) begin
    if (rst || !run || tick) cnt <= '0;
    else                     cnt <= cnt + 10'd1;
  end

  // transaction FSM with registered bus drives and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      done       <= 1'b0;
      nack       <= 1'b0;
      busy       <= 1'b0;
      scl_low    <= 1'b0;
      sda_low    <= 1'b0;
      sda_smp    <= 1'b1;
      q          <= 2'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      addr_lat   <= 7'h00;
      data_lat   <= 8'h00;
      nack_flag  <= 1'b0;
      last       <= 1'b1;
      retried    <= 1'b0;
      retry_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      nack <= 1'b0;
      case (state)
        IDLE: if (req != 2'b00) state <= ARB;

        ARB: begin
          if (req == 2'b00) begin
            state <= IDLE;
          end else begin
            grant      <= win ? 2'b10 : 2'b01;
            busy       <= 1'b1;
            last       <= win;
            addr_lat   <= win ? addr1 : addr0;
            data_lat   <= win ? data1 : data0;
            shreg      <= {(win ? addr1 : addr0), 1'b0};
            nack_flag  <= 1'b0;
            retried    <= 1'b0;
            retry_pend <= 1'b0;
            sda_low    <= 1'b1;  // SDA falls while SCL is high: START
            scl_low    <= 1'b0;
            q          <= 2'd0;
            state      <= START;
          end
        end

        // hold the START condition for two ticks, then pull SCL low and
        // present the first address bit
        START: if (tick) begin
          if (q == 2'd1) begin
            scl_low <= 1'b1;
            sda_low <= ~shreg[7];
            bit_cnt <= 3'd0;
            q       <= 2'd0;
            state   <= ADDR;
          end else begin
            q <= q + 2'd1;
          end
        end

        ADDR, ACK1, DATA, ACK2: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd0: scl_low <= 1'b0;
            2'd1: sda_smp <= i2c_sda;
            2'd2: scl_low <= 1'b1;
            default: begin
              case (state)
                ADDR, DATA: begin
                  if (bit_cnt == 3'd7) begin
                    sda_low <= 1'b0;  // release SDA for the slave's ACK
                    state   <= (state == ADDR) ? ACK1 : ACK2;
                  end else begin
                    sda_low <= ~shreg[6];
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                  end
                end
                ACK1: begin
                  if (sda_smp == 1'b0) begin
                    shreg   <= data_lat;
                    sda_low <= ~data_lat[7];
                    bit_cnt <= 3'd0;
                    state   <= DATA;
                  end else begin
                    if (RETRY_EN && !retried) begin
                      retried    <= 1'b1;
                      retry_pend <= 1'b1;
                    end else begin
                      nack_flag <= 1'b1;
                    end
                    sda_low <= 1'b1;
                    state   <= STOP;
                  end
                end
                default: begin  // ACK2
                  if (sda_smp != 1'b0) nack_flag <= 1'b1;
                  sda_low <= 1'b1;
                  state   <= STOP;
                end
              endcase
            end
          endcase
        end

        // SDA low under low SCL, release SCL, then release SDA; a pending
        // retry leaves one extra tick of free bus before the repeated START
        STOP: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd0) begin
            scl_low <= 1'b0;
          end else if (q == 2'd1) begin
            sda_low <= 1'b0;
            if (!retry_pend) begin
              done  <= 1'b1;
              nack  <= nack_flag;
              state <= DONE;
            end
          end else begin
            retry_pend <= 1'b0;
            shreg      <= {addr_lat, 1'b0};
            sda_low    <= 1'b1;
            q          <= 2'd0;
            state      <= START;
          end
        end

        DONE: begin
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: random two-requester traffic with a scoreboard.
// The driver predicts each winner and outcome from the arbitration rules and
// queues it; a bus monitor (which also plays a slave ACKing address 0x2A)
// decodes SCL/SDA and checks each transaction when done pulses.
module tb_i2c_master_arbiter;
  localparam int CLK_DIV = 4;
`ifdef I2C_RETRY_ON_NACK_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct {
    int         w;
    logic [6:0] a;
    logic [7:0] d;
    bit         nk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [6:0] addr0 = 7'h00, addr1 = 7'h00;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  wire  [1:0] grant;
  wire        done, nack, busy;
  wire  [3:0] state_out;
  wire        scl_w, sda_w;
  logic       slave_pull = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   last_w = 1;
  exp_t expq[$];

  pullup (scl_w);
  pullup (sda_w);
  assign sda_w = slave_pull ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .req(req),
    .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .grant(grant), .done(done), .nack(nack), .busy(busy),
    .i2c_scl(scl_w), .i2c_sda(sda_w), .state_out(state_out)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint byte_at(input bit bq[$], input int off);
    longint v = 0;
    if (bq.size() < off + 8) return -1;
    for (int i = 0; i < 8; i++) v = (v << 1) | longint'(bq[off + i]);
    return v;
  endfunction

  // state sequence of one transaction, one nibble per visited state
  function automatic longint exp_trace(input bit nk);
    int     seq[$];
    longint c = 0;
    seq = {1, 2, 3, 4};
    if (nk && RETRY) seq = {seq, 7, 2, 3, 4};
    if (nk) seq = {seq, 7, 8};
    else    seq = {seq, 5, 6, 7, 8};
    foreach (seq[i]) c = (c << 4) | longint'(seq[i]);
    return c;
  endfunction

  function automatic logic [6:0] pick_addr();
    int r = $urandom_range(0, 9);
    if (r < 6) return 7'h2A;
    if (r < 8) return 7'h11;
    return 7'($urandom);
  endfunction

  // serve every pending request; the winner's req drops shortly after grant
  task automatic serve_all();
    int   k, w;
    bit   btb;
    exp_t e;
    btb = 1'b0;
    while (req != 2'b00) begin
      k = 0;
      do begin @(negedge clk); k++; end while (grant == 2'b00 && k < 200);
      if (grant == 2'b00) begin
        chk("grant_timeout", 0, 1);
        req = 2'b00;
        return;
      end
      if (btb) chk("b2b_gap_cycles", k, 3);
      if (req == 2'b11) w = (last_w == 0) ? 1 : 0;
      else              w = req[1] ? 1 : 0;
      e.w  = w;
      e.a  = w ? addr1 : addr0;
      e.d  = w ? data1 : data0;
      e.nk = (e.a != 7'h2A);
      expq.push_back(e);
      last_w = w;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      req[w] = 1'b0;
      if (w == 1) begin addr1 = 7'($urandom); data1 = 8'($urandom); end
      else        begin addr0 = 7'($urandom); data0 = 8'($urandom); end
      k = 0;
      while (!done && k < 4000) begin @(negedge clk); k++; end
      if (!done) chk("done_timeout", 0, 1);
      btb = (req != 2'b00);
    end
  endtask

  // bus monitor, address-0x2A slave and scoreboard checker
  initial begin : monitor
    logic       s, d, ps, pd, ack, matched, hold_bad, idle_chk;
    logic [7:0] sh;
    int         st, pst, fe, byte_idx, starts, stops, exp_st;
    bit         bq[$];
    longint     trace;
    exp_t       e;
    ps = 1'b1; pd = 1'b1; pst = 0; fe = 0; byte_idx = 0; sh = 8'h00;
    matched = 1'b0; hold_bad = 1'b0; idle_chk = 1'b0; starts = 0; stops = 0;
    trace = 0;
    forever begin
      @(negedge clk);
      s  = scl_w;
      d  = sda_w;
      st = int'(state_out);
      if (rst) begin
        slave_pull = 1'b0; ps = 1'b1; pd = 1'b1; pst = 0; fe = 0;
        idle_chk = 1'b0;
        continue;
      end
      if (idle_chk) begin
        chk("after_done_state", st, 0);
        chk("after_done_grant", grant, 0);
        chk("after_done_busy", busy, 0);
        idle_chk = 1'b0;
      end
      if (st == 1 && pst != 1) begin
        bq.delete(); trace = 0; starts = 0; stops = 0; hold_bad = 1'b0;
      end
      if (st != pst && st != 0) trace = (trace << 4) | longint'(st);
      if (st >= 2 && st <= 8 && (busy !== 1'b1 || grant == 2'b00)) hold_bad = 1'b1;
      if (s && ps) begin
        if (pd && !d) begin
          starts++; fe = -1; byte_idx = 0; matched = 1'b0; slave_pull = 1'b0;
        end else if (!pd && d) begin
          stops++;
        end
      end
      if (s && !ps) begin
        bq.push_back(d);
        sh = {sh[6:0], d};
      end
      if (!s && ps) begin
        fe++;
        if (fe == 8) begin
          ack = (byte_idx == 0) ? (sh == 8'h54) : matched;
          if (byte_idx == 0) matched = ack;
          slave_pull = ack;
        end else if (fe == 9) begin
          slave_pull = 1'b0; fe = 0; byte_idx++;
        end
      end
      if (done) begin
        if (expq.size() == 0) begin
          chk("done_expected", 0, 1);
        end else begin
          e = expq.pop_front();
          exp_st = (e.nk && RETRY) ? 2 : 1;
          chk("grant_at_done", grant, longint'(1) << e.w);
          chk("nack_at_done", nack, e.nk);
          chk("start_count", starts, exp_st);
          chk("stop_count", stops, exp_st);
          // every byte is 9 SCL pulses; each STOP raises SCL once more
          chk("scl_rise_count", bq.size(), e.nk ? 10 * exp_st : 19);
          chk("addr_byte", byte_at(bq, 0), {e.a, 1'b0});
          if (!e.nk) chk("data_byte", byte_at(bq, 9), e.d);
          chk("state_trace", trace, exp_trace(e.nk));
          chk("busy_grant_held", hold_bad, 0);
          idle_chk = 1'b1;
        end
      end
      ps = s; pd = d; pst = st;
    end
  end

  initial begin : driver
    int k;
    repeat (3) @(negedge clk);
    chk("rst_state", state_out, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scl", scl_w, 1);
    chk("rst_sda", sda_w, 1);
    rst = 1'b0;

    // first round: simultaneous requests, 0x2A/0xA5 and an absent slave
    addr0 = 7'h2A; data0 = 8'hA5; addr1 = 7'h11; data1 = 8'h3C;
    req = 2'b11;
    serve_all();

    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      addr0 = pick_addr(); data0 = 8'($urandom);
      addr1 = pick_addr(); data1 = 8'($urandom);
      req = 2'($urandom_range(1, 3));
      serve_all();
    end

    // reset in the middle of the data byte: bus released, no done
    repeat (4) @(negedge clk);
    addr0 = 7'h2A; data0 = 8'h5A; req = 2'b01;
    k = 0;
    while (state_out != 4'd5 && k < 3000) begin @(negedge clk); k++; end
    chk("reach_data", state_out, 5);
    repeat (52) @(negedge clk);
    chk("still_in_data", state_out, 5);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    chk("midrst_state", state_out, 0);
    chk("midrst_scl", scl_w, 1);
    chk("midrst_sda", sda_w, 1);
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    last_w = 1;
    repeat (40) @(negedge clk);

    // after reset requester 0 again has priority on a tie
    addr0 = 7'h2A; data0 = 8'($urandom); addr1 = 7'h2A; data1 = 8'($urandom);
    req = 2'b11;
    serve_all();
    repeat (5) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time %0t exceeded limit %0d", $time, 900000);
    $fatal(1, "watchdog");
  end

endmodule
